// File: rtl/hilo_div_seq.sv
// hilo_div_seq: multi-cycle radix-2 restoring divider for MIPS DIV/DIVU.
//
// A request is taken in IDLE. The divider then does one quotient bit per
// cycle in ON, applies the sign fix-up in FIX, and pulses done in DONE so
// that HI/LO can be written.
//
// Ports:
//   clk        in   pipeline clock, rising edge
//   rst        in   asynchronous active-high reset
//   start      in   divide request, sampled only in IDLE
//   signed_div in   1 = DIV (two's complement), 0 = DIVU; sampled with start
//   opa        in   dividend (rs); sampled with start
//   opb        in   divisor (rt); sampled with start
//   annul      in   flush of the owning instruction; aborts ON/FIX
//   stall      out  holds the pipeline while the divide is outstanding
//   done       out  one-cycle pulse; quotient/remainder valid (HI/LO write)
//   quotient   out  result for LO, registered
//   remainder  out  result for HI, registered
module hilo_div_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             signed_div,
  input  logic [WIDTH-1:0] opa,
  input  logic [WIDTH-1:0] opb,
  input  logic             annul,
  output logic             stall,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);
  localparam logic [CW-1:0] CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] ZERO_W = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] ONES_W = {WIDTH{1'b1}};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ON   = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_e;

  // Two's complement negate when n is set.
  function automatic logic [WIDTH-1:0] neg_if(input logic n, input logic [WIDTH-1:0] v);
    return n ? (~v + {{(WIDTH-1){1'b0}}, 1'b1}) : v;
  endfunction

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] dvd_q, dvd_d;     // dividend magnitude, becomes quotient bits
  logic [WIDTH-1:0] dvs_q, dvs_d;     // divisor magnitude
  logic [WIDTH-1:0] prem_q, prem_d;   // partial remainder
  logic             negq_q, negq_d;   // quotient must be negated
  logic             negr_q, negr_d;   // remainder must be negated
  logic [WIDTH-1:0] quot_q, quot_d;
  logic [WIDTH-1:0] rem_q, rem_d;

  // One restoring step: shift {prem, dvd} left by one, trial-subtract divisor.
  // The extra top bit of the trial result is the borrow.
  logic [WIDTH:0]   shifted_s;
  logic [WIDTH+1:0] trial_s;
  logic             borrow_s;

  assign shifted_s = {prem_q, dvd_q[WIDTH-1]};
  assign trial_s   = {1'b0, shifted_s} - {2'b00, dvs_q};
  assign borrow_s  = trial_s[WIDTH+1];

  // Next-state and datapath update for the divide sequence.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    dvd_d   = dvd_q;
    dvs_d   = dvs_q;
    prem_d  = prem_q;
    negq_d  = negq_q;
    negr_d  = negr_q;
    quot_d  = quot_q;
    rem_d   = rem_q;
    case (state_q)
      IDLE: begin
        if (start && !annul) begin
          if (opb == ZERO_W) begin
            // Divide by zero skips the iteration entirely.
            quot_d  = ONES_W;
            rem_d   = opa;
            state_d = DONE;
          end else begin
            dvd_d   = neg_if(signed_div & opa[WIDTH-1], opa);
            dvs_d   = neg_if(signed_div & opb[WIDTH-1], opb);
            negq_d  = signed_div & (opa[WIDTH-1] ^ opb[WIDTH-1]);
            negr_d  = signed_div & opa[WIDTH-1];
            prem_d  = ZERO_W;
            cnt_d   = {CW{1'b0}};
            state_d = ON;
          end
        end else begin
          state_d = IDLE;
        end
      end
      ON: begin
        if (annul) begin
          state_d = IDLE;
        end else begin
          if (borrow_s) begin
            prem_d = shifted_s[WIDTH-1:0];
            dvd_d  = {dvd_q[WIDTH-2:0], 1'b0};
          end else begin
            // Remainder after a successful subtract is below the divisor,
            // so it always fits in WIDTH bits.
            prem_d = trial_s[WIDTH-1:0];
            dvd_d  = {dvd_q[WIDTH-2:0], 1'b1};
          end
          cnt_d = cnt_q + CNT_ONE;
          if (cnt_q == CNT_LAST) begin
            state_d = FIX;
          end else begin
            state_d = ON;
          end
        end
      end
      FIX: begin
        if (annul) begin
          state_d = IDLE;
        end else begin
          quot_d  = neg_if(negq_q, dvd_q);
          rem_d   = neg_if(negr_q, prem_q);
          state_d = DONE;
        end
      end
      DONE: begin
        // Result is committed; annul no longer matters here.
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, operand and result registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= {CW{1'b0}};
      dvd_q   <= ZERO_W;
      dvs_q   <= ZERO_W;
      prem_q  <= ZERO_W;
      negq_q  <= 1'b0;
      negr_q  <= 1'b0;
      quot_q  <= ZERO_W;
      rem_q   <= ZERO_W;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dvd_q   <= dvd_d;
      dvs_q   <= dvs_d;
      prem_q  <= prem_d;
      negq_q  <= negq_d;
      negr_q  <= negr_d;
      quot_q  <= quot_d;
      rem_q   <= rem_d;
    end
  end

  // The IDLE term lets the pipeline stall in the same cycle the request is
  // accepted; rst gates it so every output reads 0 while reset is held.
  assign stall = ~rst & (((state_q == IDLE) & start & ~annul) |
                         (state_q == ON) | (state_q == FIX));
  assign done      = (state_q == DONE);
  assign quotient  = quot_q;
  assign remainder = rem_q;

endmodule

// File: doc/hilo_div_seq.md
# hilo_div_seq

Multi-cycle radix-2 restoring divider sequencer for the MIPS pipeline's DIV/DIVU instructions. It accepts one divide request from the execute stage and holds the pipeline with a stall while it iterates one quotient bit per cycle. It then presents the quotient (to LO) and remainder (to HI) for a single-cycle write into the HI/LO register. It owns its own state machine and operand/partial-remainder registers; the pipeline only starts it, stalls on it and consumes the result.

## Interface
- WIDTH, 32, operand/result width; counter sized ceil(log2(WIDTH))+1 bits
- clk  in  1  pipeline clock, rising edge
- rst  in  1  asynchronous, active-high reset
- start  in  1  divide request from execute stage; sampled only in IDLE
- signed_div  in  1  1 = DIV (two's complement), 0 = DIVU; sampled with start
- opa  in  WIDTH  dividend (rs); sampled with start
- opb  in  WIDTH  divisor (rt); sampled with start
- annul  in  1  flush of the owning instruction; aborts any operation in flight
- stall  out  1  holds the pipeline while the divide is outstanding
- done  out  1  one-cycle pulse; quotient/remainder valid, HI/LO write enable
- quotient  out  WIDTH  result for LO; registered
- remainder  out  WIDTH  result for HI; registered

## Operation
- States: IDLE, ON, FIX, DONE. Reset forces IDLE, counter 0, quotient 0, remainder 0, done 0, stall 0.
- IDLE: start=1 and annul=0 latches the operands and signed_div.
  - If opb==0, go to DONE with quotient=all ones and remainder=opa.
  - Otherwise latch |opa| and |opb| (magnitudes only when signed_div=1), record the dividend sign and the quotient sign (sign(opa) XOR sign(opb)), clear the partial remainder and counter, and go to ON.
- ON: one restoring step per cycle.
  - Shift {partial remainder, dividend} left 1 and trial-subtract the divisor as WIDTH+1-bit unsigned arithmetic.
  - If no borrow, keep the difference and shift in quotient bit 1; otherwise shift in 0.
  - After the WIDTH-th step (counter == WIDTH-1), go to FIX.
- FIX: when signed, negate the quotient if the quotient sign is set and negate the remainder if the dividend was negative. Load the quotient/remainder output registers. Go to DONE.
- DONE: done=1 for exactly one cycle, then IDLE.
- Outputs hold their last value until the next load, which happens in FIX or on the divide-by-zero path.
- Signed overflow 0x80000000 / 0xFFFFFFFF gives quotient 0x80000000 and remainder 0, falling out naturally from the magnitude arithmetic. No trap.
- start in any non-IDLE state is ignored; no queuing.
- annul=1 in ON or FIX: next state IDLE, no output load, no done. annul in DONE is ignored, because the result is already committed. annul with start in IDLE: request not accepted.
- stall = (state==IDLE & start & ~annul) | state==ON | state==FIX. stall is low in DONE so the pipeline advances in the same cycle HI/LO is written.

## Timing
- Request sampled at end of cycle 0. ON occupies cycles 1..WIDTH (1..32), FIX is cycle 33, DONE/done=1 is cycle 34, IDLE from cycle 35.
- A new start is accepted no earlier than cycle 35.
- stall is high in cycles 0..33 and low in cycle 34.
- Divide by zero: start in cycle 0, DONE in cycle 1, stall high in cycle 0 only.
- annul asserted in cycle k during ON/FIX: IDLE in cycle k+1, stall low in cycle k+1.
- rst asserted at any time forces IDLE with all outputs 0 immediately, independent of clk. The first start after reset release is accepted normally.

## Test plan
- DIVU 100 / 7: done exactly in cycle 34 with quotient 14 and remainder 2. stall high in cycles 0..33 and low in cycle 34.
- DIV 0xFFFFFFF9 / 2 (-7/2): quotient 0xFFFFFFFD (-3), remainder 0xFFFFFFFF (-1). DIV 7 / 0xFFFFFFFE: quotient 0xFFFFFFFD, remainder 1.
- DIV 0x80000000 / 0xFFFFFFFF: quotient 0x80000000, remainder 0. DIVU 0xFFFFFFFF / 1: quotient 0xFFFFFFFF, remainder 0.
- Divide by zero, DIVU 0x1234 / 0: done in cycle 1, quotient 0xFFFFFFFF, remainder 0x1234, stall high in cycle 0 only.
- annul in cycle 10 of a running divide:
  - IDLE in cycle 11, no done pulse, outputs unchanged.
  - A start in cycle 11 with 9 / 3 completes in cycle 45 with quotient 3, remainder 0.
  - A start pulsed during ON is ignored.
- rst asserted mid-ON in cycle 20, between clock edges: stall, done, quotient and remainder read 0 immediately. After release, a new DIVU 50 / 5 returns quotient 10, remainder 0 exactly 34 cycles after its start.
